// File: rtl/cell_comm_pkg.sv
// Shared definitions for the cell-comm packet arbiter: arbiter FSM encoding and
// elaboration-time limits.
package cell_comm_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int MAX_NUM_INPUTS     = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } arb_state_e;

   function automatic bit num_inputs_ok(input int n);
      return (n >= 1) && (n <= MAX_NUM_INPUTS);
   endfunction

endpackage

// File: rtl/cell_comm_pkt_fifo.sv
// Per-input packet FIFO: first-word-fall-through RAM with a stored TLAST bit,
// a complete-packet counter and discard of packets longer than the FIFO depth.
module cell_comm_pkt_fifo
   import cell_comm_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_AW    = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid_i,
   input  logic                  wr_last_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  wr_ready_o,
   input  logic                  rd_pop_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_last_o,
   output logic                  pkt_avail_o,
   input  logic                  ovf_clear_i,
   output logic                  ovf_flag_o
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_W = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

   logic [DATA_WIDTH:0] mem_q [DEPTH];
   logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q;
   logic [FIFO_AW:0]    pkt_start_q, pkt_start_d;
   logic [FIFO_AW:0]    pkt_cnt_q, pkt_cnt_d;
   logic                drop_q, drop_d, ovf_q, ovf_d, en_q;
   logic                full, enter_drop, accept, wr_en, push_last, pop_last;

   // A full FIFO holding no complete packet can only contain an oversize packet.
   assign full       = (wr_ptr_q - rd_ptr_q) == DEPTH_W;
   assign enter_drop = en_q && !drop_q && full && (pkt_cnt_q == '0);
   assign wr_ready_o = en_q && (drop_q || !full);
   assign accept     = wr_valid_i && wr_ready_o;
   assign wr_en      = accept && !drop_q;
   assign push_last  = wr_en && wr_last_i;
   assign pop_last   = rd_pop_i && rd_last_o;

   assign {rd_last_o, rd_data_o} = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign pkt_avail_o = (pkt_cnt_q != '0);
   assign ovf_flag_o  = ovf_q;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path can infer a latch.
      wr_ptr_d    = wr_ptr_q;
      pkt_start_d = pkt_start_q;
      drop_d      = drop_q;
      pkt_cnt_d   = pkt_cnt_q;
      ovf_d       = ovf_q;

      if (enter_drop) begin
         wr_ptr_d = pkt_start_q;
         drop_d   = 1'b1;
      end else if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (wr_last_i) pkt_start_d = wr_ptr_q + PTR_ONE;
      end else if (drop_q && accept && wr_last_i) begin
         drop_d = 1'b0;
      end

      if (push_last && !pop_last)      pkt_cnt_d = pkt_cnt_q + PTR_ONE;
      else if (!push_last && pop_last) pkt_cnt_d = pkt_cnt_q - PTR_ONE;

      if (enter_drop)       ovf_d = 1'b1;
      else if (ovf_clear_i) ovf_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         pkt_start_q <= '0;
         pkt_cnt_q   <= '0;
         drop_q      <= 1'b0;
         ovf_q       <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         pkt_start_q <= pkt_start_d;
         pkt_cnt_q   <= pkt_cnt_d;
         drop_q      <= drop_d;
         ovf_q       <= ovf_d;
         en_q        <= 1'b1;
         if (rd_pop_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // NOTE: the storage array has no reset; pointers alone define which words are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {wr_last_i, wr_data_i};
   end

endmodule

// File: rtl/cell_comm_packet_arbiter.sv
// Packet-mode N:1 AXI-Stream arbiter: per-input packet FIFOs, round-robin grant
// held for a whole packet, merged stream towards one Aurora TX lane.
module cell_comm_packet_arbiter
   import cell_comm_pkg::*;
#(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FIFO_AW    = 5
) (
   input  logic                             axisUserClk,
   input  logic                             axisUserReset,
   input  logic [NUM_INPUTS-1:0]            sAxisTvalid,
   input  logic [NUM_INPUTS-1:0]            sAxisTlast,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] sAxisTdata,
   output logic [NUM_INPUTS-1:0]            sAxisTready,
   input  logic [NUM_INPUTS-1:0]            arbSuppress,
   output logic                             mAxisTvalid,
   output logic                             mAxisTlast,
   output logic [DATA_WIDTH-1:0]            mAxisTdata,
   input  logic                             mAxisTready,
   output logic [NUM_INPUTS-1:0]            oversizeFlag,
   input  logic [NUM_INPUTS-1:0]            oversizeClear
);

   localparam int GW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   if (!num_inputs_ok(NUM_INPUTS)) begin : g_bad_num_inputs
      $error("cell_comm_packet_arbiter: NUM_INPUTS must be in 1..8");
   end

   logic [DATA_WIDTH-1:0] head_data [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] head_last, pkt_avail, pop, eligible;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last, found;
   logic [GW-1:0]         cand;
   arb_state_e            state_q, state_d;
   logic [GW-1:0]         grant_q, grant_d, last_grant_q, last_grant_d;

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_fifo
      cell_comm_pkt_fifo #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_AW    (FIFO_AW)
      ) u_fifo (
         .clk         (axisUserClk),
         .rst         (axisUserReset),
         .wr_valid_i  (sAxisTvalid[g]),
         .wr_last_i   (sAxisTlast[g]),
         .wr_data_i   (sAxisTdata[g*DATA_WIDTH +: DATA_WIDTH]),
         .wr_ready_o  (sAxisTready[g]),
         .rd_pop_i    (pop[g]),
         .rd_data_o   (head_data[g]),
         .rd_last_o   (head_last[g]),
         .pkt_avail_o (pkt_avail[g]),
         .ovf_clear_i (oversizeClear[g]),
         .ovf_flag_o  (oversizeFlag[g])
      );
   end

   assign eligible = pkt_avail & ~arbSuppress;

   always_ff @(posedge axisUserClk or posedge axisUserReset) begin
      if (axisUserReset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= GW'(NUM_INPUTS - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      pop          = '0;
      found        = 1'b0;
      cand         = '0;
      sel_data     = '0;
      sel_last     = 1'b0;
      mAxisTvalid  = 1'b0;
      mAxisTlast   = 1'b0;
      mAxisTdata   = '0;

      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant_q == GW'(i)) begin
            sel_data = head_data[i];
            sel_last = head_last[i];
         end
      end

      case (state_q)
         ST_IDLE: begin
            // Search starts just after the previous winner so every input gets a turn.
            for (int k = 1; k <= NUM_INPUTS; k++) begin
               cand = GW'((int'(last_grant_q) + k) % NUM_INPUTS);
               if (!found && eligible[cand]) begin
                  found   = 1'b1;
                  grant_d = cand;
               end
            end
            if (found) state_d = ST_SEND;
         end
         ST_SEND: begin
            mAxisTvalid = 1'b1;
            mAxisTlast  = sel_last;
            mAxisTdata  = sel_data;
            if (mAxisTready) begin
               pop[grant_q] = 1'b1;
               if (sel_last) begin
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
